// File: rtl/amax10_qsys_sysid_checker_pkg.sv
// Shared definitions for the Qsys system-ID checker: FSM state encoding,
// result codes, sysid word offsets and a counter-width helper.
package amax10_sysid_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_PASS  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  // Result codes reported on fail_code.
  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ID      = 2'd1,
    FC_TS      = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_t;

  // Word offsets inside the sysid slave.
  localparam logic SYSID_OFS_ID = 1'b0;
  localparam logic SYSID_OFS_TS = 1'b1;

  // Width of a counter that must hold values 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : amax10_sysid_pkg

// File: rtl/amax10_qsys_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the Qsys
// sysid slave. Only the signals a read master needs are carried.
interface amax10_qsys_sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface : amax10_qsys_sysid_checker_if

// File: rtl/amax10_qsys_sysid_checker_timeout.sv
// Stall watchdog for one Avalon read: a clear/enable counter that sits at
// TIMEOUT_CYCLES once reached and flags it on tc. The owner clears it on
// every new read and when it acts on tc, so tc lasts a single cycle.
module amax10_sysid_timeout
  import amax10_sysid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // Count stall cycles; saturate at the terminal value so the count never wraps.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == CNT_MAX);

endmodule : amax10_sysid_timeout

// File: rtl/amax10_qsys_sysid_checker.sv
// Boot-time / on-request check of the Qsys system-ID slave. Reads word 0
// (system ID) and, when SYSID_CHECK_TS_EN is defined, word 1 (build
// timestamp), compares them with EXPECTED_ID / EXPECTED_TS and holds a
// pass/fail verdict until the next start. A read stalled for TIMEOUT_CYCLES
// aborts the attempt; the whole sequence is retried up to RETRY_MAX times.
// Optional feature macro: SYSID_CHECK_TS_EN (timestamp read and compare).
module amax10_qsys_sysid_checker
  import amax10_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0,
  parameter logic [31:0] EXPECTED_TS    = 32'h0,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          RETRY_MAX      = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               start,
  amax10_qsys_sysid_checker_if.master        avm,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [1:0]                         fail_code,
  output logic [31:0]                        id_q,
  output logic [31:0]                        ts_q
);

`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int RETRY_W = cnt_width(RETRY_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(RETRY_MAX);

  state_t             state_q, state_d;
  fail_code_t         fc_q, fc_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic reading;     // in one of the two read states
  logic rd_strobe;   // avm_read as driven on the bus
  logic accept;      // slave delivers readdata this cycle
  logic tmo_tc;      // stall limit reached on the current read
  logic tmo_clr;
  logic tmo_en;
  logic id_ok;
  logic ts_ok;

  // ---------------------------------------------------------------------------
  // Bus-side decode. Everything is derived from the asynchronously reset state
  // register, so reset_n low drops avm_read immediately.
  // ---------------------------------------------------------------------------
  assign reading   = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  // The timeout cycle deasserts read for one cycle before retrying or failing.
  assign rd_strobe = reading && !tmo_tc;
  assign accept    = rd_strobe && !avm.avm_waitrequest;

  assign avm.avm_read    = rd_strobe;
  assign avm.avm_address = (state_q == ST_RD_TS) ? SYSID_OFS_TS : SYSID_OFS_ID;

  // Each read starts from zero: clear outside reads, on completion and after a
  // timeout; count only cycles where the slave is actually stalling us.
  assign tmo_clr = !reading || accept || tmo_tc;
  assign tmo_en  = rd_strobe && avm.avm_waitrequest;

  amax10_sysid_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .tc      (tmo_tc)
  );

  // Comparisons. Without the timestamp feature ts_q never loads and the
  // timestamp result is forced good, so FC_TS cannot be produced.
  assign id_ok = (id_q == EXPECTED_ID);
  assign ts_ok = TS_EN ? (ts_q == EXPECTED_TS) : 1'b1;

  // ---------------------------------------------------------------------------
  // FSM state, result code and retry count registers.
  // ---------------------------------------------------------------------------
  // Register sequencer state, verdict and retry count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fc_q    <= FC_NONE;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      retry_q <= retry_d;
    end
  end

  // Next-state, verdict and retry decisions.
  // NOTE: every variable gets its hold value first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    retry_d = retry_q;
    unique case (state_q)
      // Idle or holding a verdict: start launches a fresh sequence.
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_d = ST_RD_ID;
          fc_d    = FC_NONE;
          retry_d = '0;
        end
      end
      // Reads: timeout takes priority (read is already dropped that cycle).
      ST_RD_ID, ST_RD_TS: begin
        if (tmo_tc) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_RD_ID;
          end else begin
            state_d = ST_FAIL;
            fc_d    = FC_TIMEOUT;
          end
        end else if (accept) begin
          if ((state_q == ST_RD_ID) && TS_EN) begin
            state_d = ST_RD_TS;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      // Single compare cycle; a mismatch is final because slave data is fixed.
      ST_CHECK: begin
        if (!id_ok) begin
          state_d = ST_FAIL;
          fc_d    = FC_ID;
        end else if (!ts_ok) begin
          state_d = ST_FAIL;
          fc_d    = FC_TS;
        end else begin
          state_d = ST_PASS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured words. They keep the last value read so software can inspect a
  // mismatching image after a failed check.
  // ---------------------------------------------------------------------------
  // Load id_q / ts_q on the accepted beat of the matching read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q <= '0;
      ts_q <= '0;
    end else if (accept) begin
      if (state_q == ST_RD_ID) begin
        id_q <= avm.avm_readdata;
      end
      if ((state_q == ST_RD_TS) && TS_EN) begin
        ts_q <= avm.avm_readdata;
      end
    end
  end

  // Status outputs, all decoded from registered state.
  assign busy      = reading || (state_q == ST_CHECK);
  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass      = (state_q == ST_PASS);
  assign fail_code = fc_q;

endmodule : amax10_qsys_sysid_checker
